// File: rtl/mz80k_kbd_matrix.sv
// MZ-80K keyboard matrix: host key events -> 10x8 active-low matrix.
// Ports: CLK_50MHZ, RESET, PS2_KEY[10:0] in; ROW_SEL[3:0] in; KB_COL, KEY_ANY, KEY_EVENT, ERR_DROP out.
module mz80k_kbd_matrix #(
  parameter int SHIFT_LEAD = 500000,
  parameter int ROWS       = 10
) (
  input  logic        CLK_50MHZ,
  input  logic        RESET,
  input  logic [10:0] PS2_KEY,
  input  logic [3:0]  ROW_SEL,
  output logic [7:0]  KB_COL,
  output logic        KEY_ANY,
  output logic        KEY_EVENT,
  output logic        ERR_DROP
);

  localparam int CW = $clog2(SHIFT_LEAD + 1);

  typedef struct packed {
    logic       vld;
    logic [3:0] row;
    logic [2:0] col;
    logic       fsh;
  } kent_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOOKUP,
    S_APPLY,
    S_LEAD
  } state_t;

  function automatic kent_t kmap(input logic [8:0] a);
    kent_t e;
    case (a)
      9'h012, 9'h059: e = {1'b1, 4'd8, 3'd0, 1'b0};
      9'h01C:         e = {1'b1, 4'd4, 3'd0, 1'b0};
      9'h05A:         e = {1'b1, 4'd8, 3'd3, 1'b0};
      9'h175:         e = {1'b1, 4'd9, 3'd1, 1'b0};
      9'h055:         e = {1'b1, 4'd3, 3'd5, 1'b1};
      default:        e = '0;
    endcase
    return e;
  endfunction

  logic          tog_s1_q, tog_s2_q, tog_ref_q;
  state_t        st_q, st_d;
  logic          pend_full_q, pend_full_d;
  logic [9:0]    pend_q, pend_d;
  kent_t         rom_q;
  logic          cur_mk_q, cur_mk_d;
  logic [3:0]    cur_row_q, cur_row_d;
  logic [2:0]    cur_col_q, cur_col_d;
  logic          cur_fsh_q, cur_fsh_d;
  logic [7:0]    mat_q [ROWS];
  logic [7:0]    mat_d [ROWS];
  logic [2:0]    vsh_q, vsh_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    kb_col_q, kb_col_d;
  logic          key_any_q, key_any_d;
  logic          key_ev_q, key_ev_d;
  logic          err_q, err_d;

  logic          edge_w, pop, hit, set_bit, clr_bit;
  logic [7:0]    effc [ROWS];
  logic [7:0]    effn [ROWS];

  always_comb begin
    st_d        = st_q;
    pend_full_d = pend_full_q;
    pend_d      = pend_q;
    cur_mk_d    = cur_mk_q;
    cur_row_d   = cur_row_q;
    cur_col_d   = cur_col_q;
    cur_fsh_d   = cur_fsh_q;
    vsh_d       = vsh_q;
    cnt_d       = cnt_q;
    mat_d       = mat_q;
    err_d       = 1'b0;
    set_bit     = 1'b0;
    clr_bit     = 1'b0;
    hit         = 1'b0;

    // Either edge of the synchronised toggle marks a new event.
    edge_w = tog_s2_q ^ tog_ref_q;
    pop    = (st_q == S_IDLE) && pend_full_q;

    if (pop) pend_full_d = 1'b0;
    if (edge_w) begin
      if (pend_full_q && !pop) begin
        err_d = 1'b1;
      end else begin
        pend_full_d = 1'b1;
        pend_d      = PS2_KEY[9:0];
      end
    end

    for (int r = 0; r < ROWS; r++) begin
      if (cur_row_q == r[3:0]) hit = mat_q[r][cur_col_q];
    end

    case (st_q)
      S_IDLE: begin
        if (pend_full_q) begin
          st_d     = S_LOOKUP;
          cur_mk_d = pend_q[9];
        end
      end
      S_LOOKUP: begin
        cur_row_d = rom_q.row;
        cur_col_d = rom_q.col;
        cur_fsh_d = rom_q.fsh;
        if (rom_q.vld) begin
          st_d = S_APPLY;
        end else begin
          st_d  = S_IDLE;
          err_d = 1'b1;
        end
      end
      S_APPLY: begin
        st_d = S_IDLE;
        if (cur_mk_q && !hit) begin
          if (cur_fsh_q) begin
            if (vsh_q != 3'd7) vsh_d = vsh_q + 3'd1;
            cnt_d = CW'(SHIFT_LEAD);
            st_d  = S_LEAD;
          end else begin
            set_bit = 1'b1;
          end
        end else if (!cur_mk_q && hit) begin
          clr_bit = 1'b1;
          if (cur_fsh_q && vsh_q != 3'd0) vsh_d = vsh_q - 3'd1;
        end
      end
      S_LEAD: begin
        if (cnt_q <= CW'(1)) begin
          set_bit = 1'b1;
          st_d    = S_IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: st_d = S_IDLE;
    endcase

    for (int r = 0; r < ROWS; r++) begin
      if (cur_row_q == r[3:0]) begin
        if (set_bit) mat_d[r][cur_col_q] = 1'b1;
        if (clr_bit) mat_d[r][cur_col_q] = 1'b0;
      end
    end

    // Effective matrix: SHIFT key ORed with the virtual shift count.
    key_ev_d  = 1'b0;
    key_any_d = 1'b0;
    kb_col_d  = 8'hFF;
    for (int r = 0; r < ROWS; r++) begin
      effc[r] = mat_q[r];
      effn[r] = mat_d[r];
      if (r == 8) begin
        effc[r][0] = mat_q[r][0] | (vsh_q != 3'd0);
        effn[r][0] = mat_d[r][0] | (vsh_d != 3'd0);
      end
      if (effc[r] != effn[r]) key_ev_d = 1'b1;
      if (|effn[r]) key_any_d = 1'b1;
      if (ROW_SEL == r[3:0]) kb_col_d = ~effn[r];
    end
  end

  always_ff @(posedge CLK_50MHZ) begin
    tog_s1_q  <= PS2_KEY[10];
    tog_s2_q  <= tog_s1_q;
    // Tracks the synchroniser in and out of reset: no stale edge on release.
    tog_ref_q <= tog_s2_q;
    rom_q     <= kmap(pend_q[8:0]);
    if (RESET) begin
      st_q        <= S_IDLE;
      pend_full_q <= 1'b0;
      pend_q      <= '0;
      cur_mk_q    <= 1'b0;
      cur_row_q   <= '0;
      cur_col_q   <= '0;
      cur_fsh_q   <= 1'b0;
      for (int r = 0; r < ROWS; r++) mat_q[r] <= '0;
      vsh_q       <= '0;
      cnt_q       <= '0;
      kb_col_q    <= 8'hFF;
      key_any_q   <= 1'b0;
      key_ev_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      st_q        <= st_d;
      pend_full_q <= pend_full_d;
      pend_q      <= pend_d;
      cur_mk_q    <= cur_mk_d;
      cur_row_q   <= cur_row_d;
      cur_col_q   <= cur_col_d;
      cur_fsh_q   <= cur_fsh_d;
      mat_q       <= mat_d;
      vsh_q       <= vsh_d;
      cnt_q       <= cnt_d;
      kb_col_q    <= kb_col_d;
      key_any_q   <= key_any_d;
      key_ev_q    <= key_ev_d;
      err_q       <= err_d;
    end
  end

  assign KB_COL    = kb_col_q;
  assign KEY_ANY   = key_any_q;
  assign KEY_EVENT = key_ev_q;
  assign ERR_DROP  = err_q;

endmodule

// File: tb/tb_mz80k_kbd_matrix.sv
// Bench for mz80k_kbd_matrix: directed key events, scoreboard of
// expected KEY_EVENT / ERR_DROP pulses plus direct matrix reads.
module tb_mz80k_kbd_matrix;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [10:0] ps2 = '0;
  logic [3:0]  row_sel = 4'd4;
  logic [7:0]  kb_col;
  logic        key_any, key_event, err_drop;

  int checks   = 0;
  int failures = 0;
  int pulses   = 0;
  bit tog      = 1'b0;

  typedef struct {
    bit ev;
    bit dr;
    bit any;
  } exp_t;
  exp_t sb[$];

  mz80k_kbd_matrix #(
    .SHIFT_LEAD(8),
    .ROWS(10)
  ) dut (
    .CLK_50MHZ(clk),
    .RESET(rst),
    .PS2_KEY(ps2),
    .ROW_SEL(row_sel),
    .KB_COL(kb_col),
    .KEY_ANY(key_any),
    .KEY_EVENT(key_event),
    .ERR_DROP(err_drop)
  );

  always #5 clk = ~clk;

  // Monitor: every output pulse must match the next expectation.
  always @(negedge clk) begin
    if (key_event || err_drop) begin
      exp_t e;
      pulses++;
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_pulse ev=%0b drop=%0b want=none",
                 key_event, err_drop);
      end else begin
        e = sb.pop_front();
        if (key_event !== e.ev || err_drop !== e.dr ||
            (e.ev && key_any !== e.any)) begin
          failures++;
          $display("FAIL pulse ev=%0b drop=%0b any=%0b want ev=%0b drop=%0b any=%0b",
                   key_event, err_drop, key_any, e.ev, e.dr, e.any);
        end
      end
    end
  end

  task automatic push(input bit ev, input bit dr, input bit any);
    exp_t e;
    e.ev  = ev;
    e.dr  = dr;
    e.any = any;
    sb.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic send(input bit mk, input bit ext, input logic [7:0] code);
    tog = ~tog;
    ps2 = {tog, mk, ext, code};
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_col(input int r, input logic [7:0] exp);
    @(posedge clk);
    #1 row_sel = 4'(r);
    @(posedge clk);
    @(negedge clk);
    chk($sformatf("col_r%0d", r), {24'd0, kb_col}, {24'd0, exp});
  endtask

  initial begin
    int n;
    int p0;

    // 1: reset state, 'A' make/break on row 4
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_col", {24'd0, kb_col}, 32'hFF);
    chk("rst_any", {31'd0, key_any}, 32'd0);
    chk("rst_ev", {31'd0, key_event}, 32'd0);
    chk("rst_drop", {31'd0, err_drop}, 32'd0);
    push(1, 0, 1);
    send(1, 0, 8'h1C);
    n = 0;
    while (kb_col !== 8'hFE && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk("a_make_col", {24'd0, kb_col}, 32'hFE);
    cyc(5);
    push(1, 0, 0);
    send(0, 0, 8'h1C);
    cyc(10);
    chk_col(4, 8'hFF);

    // 2: '=' needs virtual shift, key follows after the lead time
    row_sel = 4'd3;
    cyc(3);
    push(1, 0, 1);
    push(1, 0, 1);
    send(1, 0, 8'h55);
    n = 0;
    while (key_any !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("vshift_any", {31'd0, key_any}, 32'd1);
    n = 0;
    while (kb_col === 8'hFF && n < 30) begin
      n++;
      @(negedge clk);
    end
    chk("lead_cycles", n, 32'd8);
    chk("lead_col", {24'd0, kb_col}, 32'hDF);
    cyc(3);
    chk_col(8, 8'hFE);
    push(1, 0, 0);
    send(0, 0, 8'h55);
    n = 0;
    while (key_event !== 1'b1 && n < 15) begin
      @(negedge clk);
      n++;
    end
    chk("brk_event", {31'd0, key_event}, 32'd1);
    chk("brk_row8", {24'd0, kb_col}, 32'hFF);
    chk_col(3, 8'hFF);

    // 3: physical shift held across '=' make/break
    push(1, 0, 1);
    send(1, 0, 8'h12);
    cyc(10);
    chk_col(8, 8'hFE);
    push(1, 0, 1);
    send(1, 0, 8'h55);
    cyc(25);
    chk_col(3, 8'hDF);
    chk_col(8, 8'hFE);
    push(1, 0, 1);
    send(0, 0, 8'h55);
    cyc(10);
    chk_col(8, 8'hFE);
    chk_col(3, 8'hFF);
    push(1, 0, 0);
    send(0, 0, 8'h12);
    cyc(10);
    chk_col(8, 8'hFF);

    // 4: unmapped code, then pending overflow during the lead time
    push(0, 1, 0);
    send(1, 0, 8'hFF);
    cyc(10);
    chk("unmapped_any", {31'd0, key_any}, 32'd0);
    chk_col(4, 8'hFF);
    push(1, 0, 1);
    send(1, 0, 8'h55);
    n = 0;
    while (key_any !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ovf_lead", {31'd0, key_any}, 32'd1);
    send(1, 0, 8'h1C);
    repeat (3) @(negedge clk);
    push(0, 1, 0);
    push(1, 0, 1);
    push(1, 0, 1);
    send(1, 0, 8'h5A);
    cyc(30);
    chk_col(4, 8'hFE);
    chk_col(3, 8'hDF);
    chk_col(8, 8'hFE);
    push(1, 0, 1);
    send(0, 0, 8'h55);
    cyc(12);
    push(1, 0, 0);
    send(0, 0, 8'h1C);
    cyc(12);

    // 5: extended cursor-up, full row sweep, typematic repeats
    push(1, 0, 1);
    send(1, 1, 8'h75);
    cyc(10);
    for (int r = 0; r < 16; r++) begin
      chk_col(r, (r == 9) ? 8'hFD : 8'hFF);
    end
    p0 = pulses;
    send(1, 1, 8'h75);
    cyc(10);
    send(1, 1, 8'h75);
    cyc(10);
    chk("repeat_events", pulses - p0, 32'd0);
    push(1, 0, 0);
    send(0, 1, 8'h75);
    cyc(10);
    chk("up_brk_any", {31'd0, key_any}, 32'd0);

    // 6: reset in the middle of a lead with keys held
    push(1, 0, 1);
    send(1, 0, 8'h1C);
    cyc(10);
    push(1, 0, 1);
    send(1, 0, 8'h55);
    cyc(10);
    row_sel = 4'd4;
    rst = 1'b1;
    ps2 = {1'b0, 1'b1, 1'b0, 8'h1C};
    @(posedge clk);
    @(negedge clk);
    chk("midrst_col", {24'd0, kb_col}, 32'hFF);
    chk("midrst_any", {31'd0, key_any}, 32'd0);
    repeat (3) @(posedge clk);
    #1 ps2[10] = 1'b1;
    tog = 1'b1;
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    p0 = pulses;
    for (int r = 0; r < 10; r++) chk_col(r, 8'hFF);
    cyc(5);
    chk("post_rst_quiet", pulses - p0, 32'd0);
    chk("post_rst_drop", {31'd0, err_drop}, 32'd0);

    chk("sb_leftover", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
